// File: rtl/hazard_pkg.sv
`default_nettype none
// hazard_pkg: shared types for the decode-stage hazard unit (rev 1.0).
package hazard_pkg;

  localparam int DEF_REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_REG_W-1:0] rd;
    logic                 is_load;
  } inflight_t;

  // The youngest producer wins: EX beats MEM.
  function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_EXMEM;
    else if (mem_hit) return FWD_MEMWB;
    else              return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// hazard_match: one source operand compared against one in-flight writer (rev 1.0).
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic             used,
  input  logic [REG_W-1:0] rs,
  input  inflight_t        entry,
  output logic             hit
);

  assign hit = used && (rs != '0) && entry.valid && (entry.rd == rs);

  logic unused_is_load;
  assign unused_is_load = entry.is_load;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// hazard_unit: decode-stage stall/bubble/forward-select unit; forwarding enabled by
// HAZARD_FORWARD_EN (rev 1.0).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             r1_used,
  input  logic             r2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic             ex_bubble,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  inflight_t ex_q, mem_q, wb_q;

  logic [1:0]            src_used;
  logic [1:0][REG_W-1:0] src_rs;
  logic [1:0]            hit_ex;
  logic [1:0]            hit_mem;
  logic                  hazard;
  logic                  accept;

  assign src_used = {r2_used, r1_used};
  assign src_rs   = {id_rs2, id_rs1};

  generate
    for (genvar s = 0; s < 2; s++) begin : g_src
      hazard_match #(.REG_W(REG_W)) u_match_ex (
        .used  (src_used[s]),
        .rs    (src_rs[s]),
        .entry (ex_q),
        .hit   (hit_ex[s])
      );
      hazard_match #(.REG_W(REG_W)) u_match_mem (
        .used  (src_used[s]),
        .rs    (src_rs[s]),
        .entry (mem_q),
        .hit   (hit_mem[s])
      );
    end
  endgenerate

`ifdef HAZARD_FORWARD_EN
  assign hazard = ex_q.is_load && (|hit_ex);
`else
  assign hazard = (|hit_ex) || (|hit_mem);
`endif

  assign stall     = id_valid && hazard && !flush;
  assign ex_bubble = stall || flush;
  assign accept    = id_valid && id_reg_write && (id_rd != '0) && !stall && !flush;

  // Tracker shifts every cycle; a stalled or flushed ID slot enters EX as invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (accept) begin
        ex_q <= '{valid: 1'b1, rd: id_rd, is_load: id_is_load};
      end else begin
        ex_q <= '0;
      end
    end
  end

  // WB is tracked for completeness only: the regfile writes through to the read port.
  logic unused_wb;
  assign unused_wb = ^wb_q;

`ifdef HAZARD_FORWARD_EN
  fwd_sel_t fwd_a_q, fwd_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (stall || flush || !id_valid) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_pick(hit_ex[0], hit_mem[0]);
      fwd_b_q <= fwd_pick(hit_ex[1], hit_mem[1]);
    end
  end

  assign ex_fwd_a = fwd_a_q;
  assign ex_fwd_b = fwd_b_q;
`else
  assign ex_fwd_a = FWD_RF;
  assign ex_fwd_b = FWD_RF;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// tb_hazard_unit: directed RV32 sequences checked against a register-age model (rev 1.0).
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int TB_CNT_W = 10;
  localparam int MAXC     = (1 << TB_CNT_W) - 1;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                id_valid = 1'b0;
  logic [4:0]          id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic                r1_used = 1'b0, r2_used = 1'b0;
  logic                id_reg_write = 1'b0, id_is_load = 1'b0, flush = 1'b0;
  logic                stall, ex_bubble;
  logic [1:0]          ex_fwd_a, ex_fwd_b;
  logic [TB_CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_unit #(.REG_W(5), .CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .r1_used      (r1_used),
    .r2_used      (r2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .ex_bubble    (ex_bubble),
    .ex_fwd_a     (ex_fwd_a),
    .ex_fwd_b     (ex_fwd_b),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each register remembers the cycle its latest writer entered EX.
  // Age 0 = writer now in EX, age 1 = now in MEM, anything older is in the regfile.
  longint cyc = 0;
  longint iss [32];
  bit     ld  [32];
  int     mfa = 0, mfb = 0, mcnt = 0;

  function automatic int age(input logic [4:0] r, input logic u);
    longint d;
    if (!u || r == 5'd0) return 99;
    d = cyc - iss[r];
    if (d >= 0 && d < 2) return int'(d);
    return 99;
  endfunction

  function automatic bit exp_stall();
    int a1, a2;
    bit hz;
    a1 = age(id_rs1, r1_used);
    a2 = age(id_rs2, r2_used);
    if (FWD) hz = (a1 == 0 && ld[id_rs1]) || (a2 == 0 && ld[id_rs2]);
    else     hz = (a1 <= 1) || (a2 <= 1);
    return id_valid && hz && !flush;
  endfunction

  function automatic int sel_of(input int a);
    if (!FWD) return 0;
    if (a == 0) return 1;
    if (a == 1) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit st, acc;
    if (!rst_n) begin
      cyc = 0;
      foreach (iss[i]) begin
        iss[i] = -1000;
        ld[i]  = 1'b0;
      end
      mfa  = 0;
      mfb  = 0;
      mcnt = 0;
    end else begin
      st  = exp_stall();
      acc = id_valid && id_reg_write && id_rd != 5'd0 && !st && !flush;
      if (st && mcnt < MAXC) mcnt++;
      if (!id_valid || st || flush) begin
        mfa = 0;
        mfb = 0;
      end else begin
        mfa = sel_of(age(id_rs1, r1_used));
        mfb = sel_of(age(id_rs2, r2_used));
      end
      cyc++;
      if (acc) begin
        iss[id_rd] = cyc;
        ld[id_rd]  = id_is_load;
      end
    end
  end

  always @(negedge clk) begin
    bit e;
    e = exp_stall();
    cmp("stall", stall, e);
    cmp("ex_bubble", ex_bubble, e | flush);
    cmp("ex_fwd_a", ex_fwd_a, mfa);
    cmp("ex_fwd_b", ex_fwd_b, mfb);
    cmp("stall_cnt", stall_cnt, mcnt);
  end

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic isld, input logic fl);
    id_valid     = v;
    id_rs1       = rs1;
    r1_used      = u1;
    id_rs2       = rs2;
    r2_used      = u2;
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = isld;
    flush        = fl;
  endtask

  // Present one instruction in ID, hold it while stalled, and check the stall count.
  task automatic issue(input string nm, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic isld, input int exp_st);
    int n;
    n = 0;
    @(posedge clk); #1;
    set_id(1'b1, rs1, u1, rs2, u2, rd, rw, isld, 1'b0);
    @(negedge clk);
    while (stall === 1'b1 && n < 5) begin
      n++;
      @(negedge clk);
    end
    cmp(nm, n, exp_st);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // lw x5,0(x1) ; add x6,x5,x2
    issue("lu_lw", 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 0);
    issue("lu_add_stalls", 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, FWD ? 1 : 2);
    idle();
    cmp("lu_fwd_a", ex_fwd_a, FWD ? 2 : 0);
    cmp("lu_fwd_b", ex_fwd_b, 0);
    cmp("lu_cnt", stall_cnt, FWD ? 1 : 2);

    // addi x5,x0,1 ; sub x7,x1,x5
    issue("alu_addi", 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 0);
    issue("alu_sub_stalls", 5'd1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, FWD ? 0 : 2);
    idle();
    cmp("alu_fwd_a", ex_fwd_a, 0);
    cmp("alu_fwd_b", ex_fwd_b, FWD ? 1 : 0);

    // addi x5 ; nop ; sw x5,0(x2)
    issue("d2_addi", 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 0);
    idle();
    issue("d2_sw_stalls", 5'd2, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, FWD ? 0 : 1);
    idle();
    cmp("d2_fwd_a", ex_fwd_a, 0);
    cmp("d2_fwd_b", ex_fwd_b, FWD ? 2 : 0);

    // lw x0,0(x1) ; add x3,x0,x0
    issue("x0_lw", 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 0);
    issue("x0_add_stalls", 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 0);
    idle();
    cmp("x0_fwd_a", ex_fwd_a, 0);
    cmp("x0_fwd_b", ex_fwd_b, 0);

    // lw x4,0(x1) ; lui x4,1 (index fields alias x4 but are unused)
    issue("lui_lw", 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 0);
    issue("lui_stalls", 5'd4, 1'b0, 5'd4, 1'b0, 5'd4, 1'b1, 1'b0, 0);
    idle();
    cmp("lui_fwd_a", ex_fwd_a, 0);

    // lw x9 ; add x10,x9,x9 with flush in the hazard cycle ; or x11,x9,x10
    issue("fl_lw", 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 0);
    @(posedge clk); #1;
    set_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);
    @(negedge clk); #1;
    cmp("fl_stall", stall, 0);
    cmp("fl_bubble", ex_bubble, 1);
    issue("fl_or_stalls", 5'd9, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0, FWD ? 0 : 1);
    idle();
    cmp("fl_fwd_a", ex_fwd_a, FWD ? 2 : 0);
    cmp("fl_fwd_b", ex_fwd_b, 0);

    // Reset asserted in the middle of a load-use stall
    issue("rst_lw", 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 0);
    @(posedge clk); #1;
    set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #1;
    cmp("rst_pre_stall", stall, 1);
    #1 rst_n = 1'b0;
    #1;
    cmp("rst_stall", stall, 0);
    cmp("rst_fwd_a", ex_fwd_a, 0);
    cmp("rst_fwd_b", ex_fwd_b, 0);
    cmp("rst_cnt", stall_cnt, 0);
    idle();
    #2 rst_n = 1'b1;

    // Saturation: lw x5,0(x5) held in ID stalls on itself every other/third cycle
    @(posedge clk); #1;
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    repeat (2300) @(posedge clk);
    idle();
    cmp("sat_cnt", stall_cnt, MAXC);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
